// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues pipelined WISHBONE reads from the current PC,
// buffers returned words for DECODE and drops responses that predate a redirect.
module fetch_queue #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_stall_i,
  output logic [AW-1:0] wb_addr_o,
  input  logic          wb_ack_i,
  input  logic [DW-1:0] wb_data_i,
  output logic          dc_valid_o,
  input  logic          dc_ready_i,
  output logic [AW-1:0] dc_addr_o,
  output logic [DW-1:0] dc_inst_o,
  input  logic          dc_valid_i,
  input  logic [AW-1:0] dc_pc_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L   = DEPTH[CW:0];
  localparam logic [CW:0] MAX_OUT_L = MAX_OUT[CW:0];

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d, hold_addr_q, push_addr;
  logic          hold_q, hold_stale_q;
  logic [CW-1:0] count_q, count_d, live_q, live_d, stale_q, stale_d;
  logic [CW-1:0] live_tmp, stale_tmp;
  logic [CW:0]   fill_sum, out_sum;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic          can_issue, accept, acc_stale, acc_live;
  logic          ack_v, ack_live, ack_stale, push, pop;
  logic [AW-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: each always_comb assigns its outputs a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (dc_valid_i) state_d = S_RUN;
  end

  always_comb begin
    fill_sum  = {1'b0, count_q} + {1'b0, live_q};
    out_sum   = {1'b0, live_q} + {1'b0, stale_q};
    can_issue = (state_q == S_RUN) && (fill_sum < DEPTH_L) && (out_sum < MAX_OUT_L);
    wb_stb_o  = hold_q | can_issue;
    wb_addr_o = hold_q ? hold_addr_q : fetch_addr_q;
    wb_cyc_o  = wb_stb_o | (out_sum != '0);
  end

  // A held request tagged stale belongs to the pre-redirect stream.
  assign accept    = wb_stb_o & ~wb_stall_i;
  assign acc_stale = accept & hold_q & hold_stale_q;
  assign acc_live  = accept & ~acc_stale;
  assign ack_v     = wb_ack_i & ((live_q != '0) | (stale_q != '0));
  assign ack_stale = ack_v & (stale_q != '0);
  assign ack_live  = ack_v & (stale_q == '0);
  assign pop       = dc_valid_o & dc_ready_i;
  assign push      = ack_live & ~dc_valid_i;
  // Live requests are consecutive, so the oldest one sits live_q words behind the fetch address.
  assign push_addr = fetch_addr_q - AW'(live_q);

  always_comb begin
    live_tmp     = live_q + CW'(acc_live) - CW'(ack_live);
    stale_tmp    = stale_q + CW'(acc_stale) - CW'(ack_stale);
    live_d       = live_tmp;
    stale_d      = stale_tmp;
    count_d      = count_q + CW'(push) - CW'(pop);
    fetch_addr_d = fetch_addr_q + AW'(acc_live);
    if (dc_valid_i) begin
      stale_d      = stale_tmp + live_tmp;
      live_d       = '0;
      count_d      = '0;
      fetch_addr_d = dc_pc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fetch_addr_q <= '0;
      hold_addr_q  <= '0;
      hold_q       <= 1'b0;
      hold_stale_q <= 1'b0;
      count_q      <= '0;
      live_q       <= '0;
      stale_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      hold_addr_q  <= wb_addr_o;
      hold_q       <= wb_stb_o & wb_stall_i;
      hold_stale_q <= wb_stb_o & wb_stall_i & (dc_valid_i | (hold_q & hold_stale_q));
      count_q      <= count_d;
      live_q       <= live_d;
      stale_q      <= stale_d;
      if (dc_valid_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; outputs are gated by dc_valid_o instead.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_addr[wr_ptr_q] <= push_addr;
      q_data[wr_ptr_q] <= wb_data_i;
    end
  end

  assign dc_valid_o = (count_q != '0);
  assign dc_addr_o  = dc_valid_o ? q_addr[rd_ptr_q] : '0;
  assign dc_inst_o  = dc_valid_o ? q_data[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: cycle table for start-up and back-pressure, directed
// redirect/stall/wrap/reset sequences, then random traffic against a stream model.
module tb_fetch_queue;
  localparam int AW = 16, DW = 16, DEPTH = 4, MAX_OUT = 2;

  logic          clk_i = 1'b0, rstn_i;
  logic          wb_cyc_o, wb_stb_o, wb_stall_i, wb_ack_i;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_data_i;
  logic          dc_valid_o, dc_ready_i, dc_valid_i;
  logic [AW-1:0] dc_addr_o, dc_pc_i;
  logic [DW-1:0] dc_inst_o;

  fetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_stall_i(wb_stall_i),
    .wb_addr_o(wb_addr_o), .wb_ack_i(wb_ack_i), .wb_data_i(wb_data_i),
    .dc_valid_o(dc_valid_o), .dc_ready_i(dc_ready_i), .dc_addr_o(dc_addr_o),
    .dc_inst_o(dc_inst_o), .dc_valid_i(dc_valid_i), .dc_pc_i(dc_pc_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0, n_errors = 0, pops = 0;

  // Slave model and decode-stream model
  logic [AW-1:0] resp_q[$];
  logic [AW-1:0] exp_addr, prev_addr, prev_dca;
  logic [DW-1:0] prev_dci;
  bit            pc_known, prev_held, prev_rv, prev_head_wait, spur_ack;

  typedef struct {
    logic          rv;
    logic [AW-1:0] pc;
    logic          st;
    logic          rd;
    logic          exp_stb;
    logic [AW-1:0] exp_addr;
    logic          exp_dcv;
    logic [AW-1:0] exp_dca;
  } vec_t;
  vec_t vecs[14];

  function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    resp_q.delete();
    pc_known = 0; prev_held = 0; prev_rv = 0; prev_head_wait = 0;
    exp_addr = '0; prev_addr = '0; prev_dca = '0; prev_dci = '0;
  endtask

  // Asserts reset at the current time (never on a clock edge) and checks outputs at once.
  task automatic do_reset();
    rstn_i = 1'b0;
    dc_valid_i = 0; dc_pc_i = '0; wb_stall_i = 0; wb_ack_i = 0; wb_data_i = '0; dc_ready_i = 0;
    #1;
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_addr", wb_addr_o, 0);
    check("rst_dcv", dc_valid_o, 0);
    check("rst_dca", dc_addr_o, 0);
    check("rst_dci", dc_inst_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rstn_i = 1'b1;
    @(posedge clk_i); #1;
    clear_model();
  endtask

  // One clock cycle: drive inputs, sample outputs, check against the models, advance.
  task automatic step(input logic rv, input logic [AW-1:0] pc, input logic st,
                      input logic ak_en, input logic rd);
    logic          stb, dcv, ack;
    logic [AW-1:0] addr, dca;
    logic [DW-1:0] dci;
    dc_valid_i = rv; dc_pc_i = pc; wb_stall_i = st; dc_ready_i = rd;
    ack = spur_ack || (ak_en && resp_q.size() > 0);
    wb_ack_i  = ack;
    wb_data_i = (resp_q.size() > 0) ? inst_of(resp_q[0]) : 16'($urandom);
    #1;
    stb = wb_stb_o; addr = wb_addr_o; dcv = dc_valid_o; dca = dc_addr_o; dci = dc_inst_o;
    check("cyc", wb_cyc_o, stb || resp_q.size() > 0);
    if (prev_held) begin
      check("hold_stb", stb, 1);
      check("hold_addr", addr, prev_addr);
    end
    if (!pc_known) begin
      check("idle_stb", stb, 0);
      check("idle_dcv", dcv, 0);
    end
    if (prev_rv) check("flush_dcv", dcv, 0);
    if (prev_head_wait) begin
      check("head_valid", dcv, 1);
      check("head_stable", {dca, dci}, {prev_dca, prev_dci});
    end
    if (dcv && rd && !rv) begin
      check("pop_addr", dca, exp_addr);
      check("pop_inst", dci, inst_of(exp_addr));
      exp_addr++;
      pops++;
    end
    if (stb && !st) check("max_out", resp_q.size() < MAX_OUT, 1);
    if (ack && resp_q.size() > 0) void'(resp_q.pop_front());
    if (stb && !st) resp_q.push_back(addr);
    prev_held = stb && st; prev_addr = addr; prev_rv = rv;
    prev_head_wait = dcv && !rd && !rv; prev_dca = dca; prev_dci = dci;
    if (rv) begin
      exp_addr = pc;
      pc_known = 1;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 1, 1);
  endtask

  initial begin
    rstn_i = 1'b0; spur_ack = 0;
    dc_valid_i = 0; dc_pc_i = '0; wb_stall_i = 0; wb_ack_i = 0; wb_data_i = '0; dc_ready_i = 0;
    clear_model();

    // Start-up from 0x0100 with one-cycle acks, then six cycles of DECODE back-pressure.
    vecs[0]  = '{1'b1, 16'h0100, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0101, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0102, 1'b1, 16'h0100};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0103, 1'b1, 16'h0101};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0104, 1'b1, 16'h0102};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0105, 1'b1, 16'h0103};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0106, 1'b1, 16'h0103};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0103};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0103};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0103};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0103};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0103};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0107, 1'b1, 16'h0104};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      check($sformatf("vec%0d_stb", i), wb_stb_o, vecs[i].exp_stb);
      if (vecs[i].exp_stb) check($sformatf("vec%0d_addr", i), wb_addr_o, vecs[i].exp_addr);
      check($sformatf("vec%0d_dcv", i), dc_valid_o, vecs[i].exp_dcv);
      if (vecs[i].exp_dcv) check($sformatf("vec%0d_dca", i), dc_addr_o, vecs[i].exp_dca);
      step(vecs[i].rv, vecs[i].pc, vecs[i].st, 1'b1, vecs[i].rd);
    end
    run(6);

    // Redirect with two reads outstanding: both responses must be dropped.
    do_reset();
    step(1, 16'h0180, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    check("two_outstanding", resp_q.size(), 2);
    check("max_out_blocks_stb", wb_stb_o, 0);
    step(1, 16'h0200, 0, 0, 1);
    run(14);
    check("redirect_progress", exp_addr >= 16'h0204, 1);

    // Stall held for three cycles with a redirect in the second.
    do_reset();
    step(1, 16'h0300, 0, 1, 1);
    run(4);
    step(0, '0, 1, 1, 1);
    step(1, 16'h0400, 1, 1, 1);
    step(0, '0, 1, 1, 1);
    step(0, '0, 0, 1, 1);
    check("new_pc_stb", wb_stb_o, 1);
    check("new_pc_addr", wb_addr_o, 16'h0400);
    run(12);
    check("stall_redirect_progress", exp_addr >= 16'h0404, 1);

    // Address wrap from 0xFFFE.
    do_reset();
    step(1, 16'hFFFE, 0, 1, 1);
    run(10);
    check("wrap_progress", (exp_addr >= 16'h0001) && (exp_addr <= 16'h0010), 1);

    // Reset mid-burst, spurious acks while idle, then a fresh stream.
    do_reset();
    step(1, 16'h0600, 0, 1, 1);
    run(5);
    do_reset();
    spur_ack = 1;
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    spur_ack = 0;
    step(1, 16'h0500, 0, 1, 1);
    run(10);
    check("post_reset_progress", exp_addr >= 16'h0504, 1);

    // Random traffic against the stream model.
    do_reset();
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 39) == 0, 16'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    check("random_progress", pops > 300, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter AW, default 16: WISHBONE and PC address width in bits.
REQ-002 Parameter DW, default 16: instruction word width in bits.
REQ-003 Parameter DEPTH, default 4: instruction queue depth; power of two, >= 2.
REQ-004 Parameter MAX_OUT, default 2: maximum outstanding WISHBONE reads, including stale ones; 1 <= MAX_OUT <= DEPTH.
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 wb_cyc_o  out  1  bus cycle active.
REQ-008 wb_stb_o  out  1  read request strobe; pipelined mode; wb_we is always 0.
REQ-009 wb_stall_i  in  1  slave cannot accept the request this cycle.
REQ-010 wb_addr_o  out  AW  word address of the request.
REQ-011 wb_ack_i  in  1  read response; in request order; one per accepted request.
REQ-012 wb_data_i  in  DW  read data, valid with wb_ack_i.
REQ-013 dc_valid_o  out  1  queue head valid.
REQ-014 dc_ready_i  in  1  DECODE accepts the head.
REQ-015 dc_addr_o  out  AW  address of the head instruction.
REQ-016 dc_inst_o  out  DW  head instruction word.
REQ-017 dc_valid_i  in  1  new PC from DECODE (redirect).
REQ-018 dc_pc_i  in  AW  redirect target address.

Function
REQ-019 State machine: IDLE (no PC known) and RUN; after reset the state is IDLE; dc_valid_i moves any state to RUN with fetch address := dc_pc_i.
REQ-020 Request accepted = wb_stb_o && !wb_stall_i; on acceptance the fetch address increments by 1, modulo 2^AW (wrap from all-ones to 0).
REQ-021 In RUN, wb_stb_o is asserted when queue_count + live_out < DEPTH and live_out + stale_out < MAX_OUT, with wb_addr_o = fetch address.
REQ-022 While wb_stb_o && wb_stall_i, wb_stb_o and wb_addr_o are held unchanged into the next cycle, even across a redirect.
REQ-023 wb_cyc_o is high whenever wb_stb_o is high or live_out + stale_out > 0; otherwise low.
REQ-024 An ack decrements stale_out when stale_out > 0, and the data is discarded; otherwise it decrements live_out and pushes {address, wb_data_i} into the queue.
REQ-025 Queue head drives dc_valid_o, dc_addr_o and dc_inst_o; the head is popped on dc_valid_o && dc_ready_i.
REQ-026 While dc_valid_o && !dc_ready_i, dc_valid_o, dc_addr_o and dc_inst_o are stable.
REQ-027 Push and pop in the same cycle keep queue_count unchanged; a full queue never receives a push (guaranteed by REQ-021).
REQ-028 Ack-to-dc_valid_o latency is 1 cycle when the queue was empty.
REQ-029 Redirect (dc_valid_i): the queue is emptied, dc_valid_o is 0 the next cycle, and stale_out := stale_out + live_out (counting a request accepted this cycle, excluding an ack consumed this cycle); live_out := 0.
REQ-030 Redirect in the same cycle as a pop: the redirect wins and the pop has no further effect.
REQ-031 Redirect in the same cycle as an ack: the ack belongs to the old stream and is handled per REQ-024 before the reclassification.
REQ-032 A request still held stalled at redirect (REQ-022) is counted stale on acceptance; the first new-PC request is issued on the cycle after it.
REQ-033 Requests from the new PC are issued while stale acks drain, subject to REQ-021.
REQ-034 Counters queue_count, live_out and stale_out are clog2(DEPTH)+1 bits wide and never overflow or underflow.

Reset
REQ-035 rstn_i low asynchronously forces wb_cyc_o=0, wb_stb_o=0, wb_addr_o=0, dc_valid_o=0, dc_addr_o=0, dc_inst_o=0, all counters=0 and state IDLE.
REQ-036 Reset asserted mid-transfer abandons outstanding reads; acks received while wb_cyc_o=0 are ignored.
REQ-037 Reset release is synchronous to clk_i; no request is issued before the first dc_valid_i.

Verification
REQ-038 Reset, then dc_pc_i=0x0100 with dc_valid_i and no stall, ack 1 cycle after request, dc_ready_i=1 -> dc_addr_o sequence 0x0100, 0x0101, ... with matching data.
REQ-039 dc_ready_i=0 for 6 cycles -> exactly DEPTH=4 reads issued, queue full, head stable, wb_stb_o low.
REQ-040 Redirect to 0x0200 with 2 reads outstanding -> those 2 acks are discarded, first dc_addr_o after redirect is 0x0200.
REQ-041 wb_stall_i=1 for 3 cycles with redirect in the 2nd stall cycle -> wb_addr_o held, its ack discarded, next request at new PC.
REQ-042 Fetch from PC 0xFFFE (AW=16) -> dc_addr_o sequence 0xFFFE, 0xFFFF, 0x0000.
REQ-043 rstn_i pulsed low mid-burst -> all outputs 0 immediately, no request until next dc_valid_i.
